// File: rtl/resp_arbiter.sv
// Packet-level round-robin arbiter sharing one uplink response stream between adc, flash and ctrl.
// Latency: grant 1 cycle after a request is sampled in IDLE; granted beats appear on o_resp_* 1 cycle later.
// Backpressure: none on the uplink; stalled owners are aborted after P_TIMEOUT beat-less cycles.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_<ch>_req/len/data/last/valid  per-requester packet stream (ch = adc, flash, ctrl)
//   o_<ch>_grant                 requester currently owns the uplink
//   o_resp_len/data/last/valid   registered copy of the owner's beat (all zero when no beat)
//   o_owner                      0 none, 1 adc, 2 flash, 3 ctrl
//   o_busy                       arbiter not idle (transfer or inter-packet gap)
//   o_abort                      one-cycle pulse when a packet is cut short
module resp_arbiter #(
    parameter int P_GAP     = 2,
    parameter int P_TIMEOUT = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_adc_req,
    output logic       o_adc_grant,
    input  logic [7:0] i_adc_len,
    input  logic [7:0] i_adc_data,
    input  logic       i_adc_last,
    input  logic       i_adc_valid,
    input  logic       i_flash_req,
    output logic       o_flash_grant,
    input  logic [7:0] i_flash_len,
    input  logic [7:0] i_flash_data,
    input  logic       i_flash_last,
    input  logic       i_flash_valid,
    input  logic       i_ctrl_req,
    output logic       o_ctrl_grant,
    input  logic [7:0] i_ctrl_len,
    input  logic [7:0] i_ctrl_data,
    input  logic       i_ctrl_last,
    input  logic       i_ctrl_valid,
    output logic [7:0] o_resp_len,
    output logic [7:0] o_resp_data,
    output logic       o_resp_last,
    output logic       o_resp_valid,
    output logic [1:0] o_owner,
    output logic       o_busy,
    output logic       o_abort
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int              CW       = $clog2(P_TIMEOUT);
    localparam logic [CW-1:0]   TO_LAST  = CW'(P_TIMEOUT - 1);
    localparam logic [3:0]      GAP_LAST = (P_GAP > 0) ? 4'(P_GAP - 1) : 4'd0;
    // With no gap configured a finished packet returns straight to IDLE.
    localparam state_t          ST_AFTER = (P_GAP > 0) ? ST_GAP : ST_IDLE;

    // Channel index 0 adc, 1 flash, 2 ctrl; o_owner is index + 1.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    own_q, own_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    gap_q, gap_d;
    logic [7:0]    resp_len_q, resp_len_d;
    logic [7:0]    resp_data_q, resp_data_d;
    logic          resp_last_q, resp_last_d;
    logic          resp_valid_q, resp_valid_d;
    logic          abort_q, abort_d;

    logic [2:0]    req_v;
    logic [1:0]    cand0, cand1, cand2, win_idx;
    logic          sel_req, sel_valid, sel_last;
    logic [7:0]    sel_len, sel_data;
    logic          in_xfer, pkt_end, req_lost, stalled_out, xfer_abort, fwd;

    assign req_v = {i_ctrl_req, i_flash_req, i_adc_req};

    // Owner's stream; other channels are never looked at.
    always_comb begin
        sel_req   = 1'b0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_len   = 8'd0;
        sel_data  = 8'd0;
        case (own_q)
            2'd0: begin
                sel_req   = i_adc_req;
                sel_valid = i_adc_valid;
                sel_last  = i_adc_last;
                sel_len   = i_adc_len;
                sel_data  = i_adc_data;
            end
            2'd1: begin
                sel_req   = i_flash_req;
                sel_valid = i_flash_valid;
                sel_last  = i_flash_last;
                sel_len   = i_flash_len;
                sel_data  = i_flash_data;
            end
            2'd2: begin
                sel_req   = i_ctrl_req;
                sel_valid = i_ctrl_valid;
                sel_last  = i_ctrl_last;
                sel_len   = i_ctrl_len;
                sel_data  = i_ctrl_data;
            end
            default: ;
        endcase
    end

    // Round-robin search starting at the pointer itself.
    always_comb begin
        cand0   = ptr_q;
        cand1   = rr_next(ptr_q);
        cand2   = rr_next(cand1);
        win_idx = ptr_q;
        if (req_v[cand0])      win_idx = cand0;
        else if (req_v[cand1]) win_idx = cand1;
        else if (req_v[cand2]) win_idx = cand2;
    end

    // A last beat completes the packet even if req drops in the same cycle.
    assign in_xfer     = (state_q == ST_XFER);
    assign pkt_end     = in_xfer && sel_valid && sel_last;
    assign req_lost    = in_xfer && !sel_req && !pkt_end;
    assign stalled_out = in_xfer && sel_req && !sel_valid && (cnt_q == TO_LAST);
    assign xfer_abort  = req_lost || stalled_out;
    assign fwd         = in_xfer && sel_valid && (sel_req || sel_last);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            own_q        <= 2'd0;
            ptr_q        <= 2'd0;
            cnt_q        <= '0;
            gap_q        <= 4'd0;
            resp_len_q   <= 8'd0;
            resp_data_q  <= 8'd0;
            resp_last_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            own_q        <= own_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            resp_len_q   <= resp_len_d;
            resp_data_q  <= resp_data_d;
            resp_last_q  <= resp_last_d;
            resp_valid_q <= resp_valid_d;
            abort_q      <= abort_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_v) begin
                    state_d = ST_XFER;
                    own_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            ST_XFER: begin
                if (pkt_end || xfer_abort) begin
                    state_d = ST_AFTER;
                    ptr_d   = rr_next(own_q);
                    gap_d   = 4'd0;
                    cnt_d   = '0;
                end else if (sel_valid) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        resp_len_d   = fwd ? sel_len  : 8'd0;
        resp_data_d  = fwd ? sel_data : 8'd0;
        resp_last_d  = fwd && sel_last;
        resp_valid_d = fwd;
        abort_d      = xfer_abort;
    end

    assign o_adc_grant   = in_xfer && (own_q == 2'd0);
    assign o_flash_grant = in_xfer && (own_q == 2'd1);
    assign o_ctrl_grant  = in_xfer && (own_q == 2'd2);
    assign o_owner       = in_xfer ? (own_q + 2'd1) : 2'd0;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_resp_len    = resp_len_q;
    assign o_resp_data   = resp_data_q;
    assign o_resp_last   = resp_last_q;
    assign o_resp_valid  = resp_valid_q;
    assign o_abort       = abort_q;

endmodule
